sdram_cmd_seq: RTL and testbench
================================

SDRAM_CMD_SEQ -- requirements
Module: sdram_cmd_seq

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- INIT_WAIT, 16: NOP cycles after reset before init precharge.
- TRCD, 2: cycles from ACT to RD/WR.
- CL, 2: read CAS latency in cycles.
- TWR, 2: write recovery cycles.
- TRP, 2: precharge period in cycles.
- TRFC, 6: refresh cycle time in cycles.
- TREFI, 64: refresh interval in cycles.
- MODE, 12'h022: value driven on sd_adrs during MRS.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: sole clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high.
- req_valid, in, 1: request present.
- req_ready, out, 1: sequencer can accept a request.
- req_write, in, 1: 1 = write, 0 = read.
- req_bank, in, 2: bank address.
- req_row, in, 12: row address.
- req_col, in, 10: column address.
- req_mask, in, 8: write byte mask, active-low, driven onto sd_dqm_l.
- rsp_done, out, 1: one-cycle pulse when an access completes.
- init_done, out, 1: high once initialisation completes.
- ref_overrun, out, 1: sticky flag, a refresh interval expired while a refresh was still pending.
- sd_cs_, sd_ras_, sd_cas_, sd_we_, out, 1 each: SDRAM command pins, active-low.
- sd_ba, out, 2: bank pins.
- sd_adrs, out, 12: address pins.
- sd_dqm_l, out, 8: byte masks, active-low.

Function
REQ-003 Commands as {cs_,ras_,cas_,we_} SHALL be: DESEL 1111, NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000; all command pins registered.

REQ-004 The FSM SHALL have states INIT_WAIT, INIT_PRE, INIT_RP, INIT_REF, INIT_RFC, INIT_MRS, IDLE, ACT, RCD, RW, RWAIT, PRE, RP, REF, RFC.

REQ-005 Initialisation SHALL run as follows:
- INIT_WAIT issues NOP for INIT_WAIT cycles.
- INIT_PRE issues PRE-all (sd_adrs[10]=1), followed by TRP-1 NOPs.
- Two REF commands follow, each followed by TRFC-1 NOPs.
- INIT_MRS issues MRS with sd_adrs=MODE and sd_ba=0.
- The FSM then enters IDLE, and init_done rises in the same cycle and stays high until reset.

REQ-006 req_ready SHALL be high only in IDLE with no refresh pending; a request is accepted on an edge where req_valid and req_ready are both high, and all req_* fields are latched on that edge.

REQ-007 Access sequence, with acceptance on edge E0 (cycle numbers relative to E0):
- Cycle 1: ACT with ba=bank, adrs=row.
- Cycles 2..TRCD: NOP.
- Cycle TRCD+1: RD or WR with adrs={2'b00,col} (bit 10=0, no auto-precharge).
- Next CL (read) or TWR (write) cycles: NOP.
- Next cycle: PRE with adrs[10]=0, ba=bank.
- Next TRP cycles: NOP.
- Following cycle: IDLE with rsp_done=1.

REQ-008 sd_dqm_l SHALL equal the latched req_mask in the WR cycle, 8'h00 from the RD cycle through its CL following cycles, and 8'hFF at all other times.

REQ-009 sd_ba and sd_adrs SHALL hold their last values during NOP cycles; they are don't-care for the bench.

REQ-010 The refresh counter SHALL behave as follows:
- It starts counting when init_done rises.
- It wraps at TREFI-1.
- On wrap it sets ref_pend.
- Issuing REF clears ref_pend.
- A wrap while ref_pend is already set sets ref_overrun, which is sticky until reset.

REQ-011 In IDLE, ref_pend SHALL take priority over req_valid: REF is issued the next cycle, followed by TRFC-1 NOPs, then a return to IDLE. A request arriving in the same cycle is not accepted (req_ready=0) and waits.

REQ-012 A refresh expiring during an access SHALL NOT interrupt it; it is serviced at the next IDLE.

REQ-013 No back-to-back accesses SHALL bypass PRE (closed-page policy); rsp_done never pulses outside REQ-007.

Reset
REQ-014 Reset SHALL apply as follows:
- While reset is high, and in the cycle after it is sampled: command=DESEL, sd_ba=0, sd_adrs=0, sd_dqm_l=8'hFF.
- req_ready, rsp_done, init_done and ref_overrun are 0.
- The refresh counter and ref_pend are 0.
- The state is INIT_WAIT.

REQ-015 Reset asserted at any point, including mid-access or mid-refresh, SHALL abort the operation without a completing PRE or rsp_done, and re-run full initialisation.

Verification
REQ-016 Defaults, release reset -> 16 NOP, PRE with adrs[10]=1, 1 NOP, REF, 5 NOP, REF, 5 NOP, MRS with adrs=12'h022, then init_done=1 and req_ready=1.

REQ-017 Read bank=2, row=12'h5A5, col=10'h3C -> ACT(ba=2, adrs=5A5), NOP, RD(adrs=03C), dqm_l=00 for 3 cycles, PRE(ba=2), 2 NOP, rsp_done one cycle 9 cycles after acceptance.

REQ-018 Write, mask=8'hF0 -> WR cycle shows dqm_l=F0, FF otherwise; rsp_done at the same cycle offset as the read.

REQ-019 req_valid held high continuously with refresh expiring in the same cycle as IDLE -> REF is issued first, the request is accepted TRFC cycles later, and its data is unchanged.

REQ-020 TREFI=8 with back-to-back accesses -> ref_overrun sets and stays high until reset; REF is still issued at each IDLE.

REQ-021 Reset asserted in the RCD cycle -> next cycle DESEL, no PRE, no rsp_done, init_done=0, and the init sequence of REQ-016 repeats.

Source files
------------

// File: rtl/sdram_cmd_seq.sv
// Closed-page SDRAM command sequencer: power-up init, one access at a time, periodic auto-refresh.
// Command, bank, address and mask pins are all registered. Assumes TRCD, TRP, TRFC >= 2 and CL, TWR >= 1.
//
// state       | meaning
// ------------+------------------------------------------------------------
// INIT_WAIT   | post-reset NOP wait (first cycle after reset shows DESEL)
// INIT_PRE    | precharge-all command
// INIT_RP     | precharge period, TRP-1 NOPs
// INIT_REF    | init refresh command (issued twice)
// INIT_RFC    | refresh cycle time, TRFC-1 NOPs
// INIT_MRS    | mode register set with MODE
// IDLE        | waiting for a request or a pending refresh
// ACT         | row activate
// RCD         | ACT-to-column delay, TRCD-1 NOPs
// RW          | read or write command
// RWAIT       | CAS latency (read) or write recovery (write)
// PRE         | single-bank precharge closing the row
// RP          | precharge period, TRP NOPs
// REF         | periodic refresh command
// RFC         | refresh cycle time, TRFC-1 NOPs
module sdram_cmd_seq #(
  parameter int unsigned INIT_WAIT = 16,
  parameter int unsigned TRCD      = 2,
  parameter int unsigned CL        = 2,
  parameter int unsigned TWR       = 2,
  parameter int unsigned TRP       = 2,
  parameter int unsigned TRFC      = 6,
  parameter int unsigned TREFI     = 64,
  parameter logic [11:0] MODE      = 12'h022
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_bank,
  input  logic [11:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [7:0]  req_mask,
  output logic        rsp_done,
  output logic        init_done,
  output logic        ref_overrun,
  output logic        sd_cs_,
  output logic        sd_ras_,
  output logic        sd_cas_,
  output logic        sd_we_,
  output logic [1:0]  sd_ba,
  output logic [11:0] sd_adrs,
  output logic [7:0]  sd_dqm_l
);

  localparam int TW = 16;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_RD    = 4'b0101;
  localparam logic [3:0] CMD_WR    = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  typedef enum logic [3:0] {
    ST_INIT_WAIT, ST_INIT_PRE, ST_INIT_RP, ST_INIT_REF, ST_INIT_RFC, ST_INIT_MRS,
    ST_IDLE, ST_ACT, ST_RCD, ST_RW, ST_RWAIT, ST_PRE, ST_RP, ST_REF, ST_RFC
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tmr, tmr_nx;
  logic            init_ref2, init_ref2_nx;
  logic [TW-1:0]   ref_cnt;
  logic            ref_pend;
  logic            ref_wrap, ref_issue, accept;
  logic [3:0]      cmd_q, cmd_nx;
  logic [1:0]      ba_nx;
  logic [11:0]     adrs_nx;
  logic [7:0]      dqm_nx;
  logic            wr_q;
  logic [1:0]      bank_q;
  logic [9:0]      col_q;
  logic [7:0]      mask_q;

  assign req_ready = (state == ST_IDLE) && !ref_pend;
  assign accept    = req_valid && req_ready;
  assign ref_issue = (state == ST_IDLE) && ref_pend;
  assign ref_wrap  = init_done && (ref_cnt == TW'(TREFI - 1));
  assign {sd_cs_, sd_ras_, sd_cas_, sd_we_} = cmd_q;

  always_comb begin
    state_nx     = state;
    tmr_nx       = (tmr == '0) ? '0 : tmr - 1'b1;
    init_ref2_nx = init_ref2;
    case (state)
      ST_INIT_WAIT: if (tmr == '0) state_nx = ST_INIT_PRE;
      ST_INIT_PRE: begin
        state_nx = ST_INIT_RP;
        tmr_nx   = TW'(TRP - 2);
      end
      ST_INIT_RP:   if (tmr == '0) state_nx = ST_INIT_REF;
      ST_INIT_REF: begin
        state_nx = ST_INIT_RFC;
        tmr_nx   = TW'(TRFC - 2);
      end
      ST_INIT_RFC: begin
        if (tmr == '0) begin
          state_nx     = init_ref2 ? ST_INIT_MRS : ST_INIT_REF;
          init_ref2_nx = 1'b1;
        end
      end
      ST_INIT_MRS:  state_nx = ST_IDLE;
      ST_IDLE: begin
        // a due refresh always wins over a waiting request
        if (ref_pend)       state_nx = ST_REF;
        else if (req_valid) state_nx = ST_ACT;
      end
      ST_ACT: begin
        state_nx = ST_RCD;
        tmr_nx   = TW'(TRCD - 2);
      end
      ST_RCD:       if (tmr == '0) state_nx = ST_RW;
      ST_RW: begin
        state_nx = ST_RWAIT;
        tmr_nx   = wr_q ? TW'(TWR - 1) : TW'(CL - 1);
      end
      ST_RWAIT:     if (tmr == '0) state_nx = ST_PRE;
      ST_PRE: begin
        state_nx = ST_RP;
        tmr_nx   = TW'(TRP - 1);
      end
      ST_RP:        if (tmr == '0) state_nx = ST_IDLE;
      ST_REF: begin
        state_nx = ST_RFC;
        tmr_nx   = TW'(TRFC - 2);
      end
      ST_RFC:       if (tmr == '0) state_nx = ST_IDLE;
      default:      state_nx = ST_INIT_WAIT;
    endcase

    // pins are registered, so they are decoded from the state being entered
    cmd_nx  = CMD_NOP;
    ba_nx   = sd_ba;
    adrs_nx = sd_adrs;
    dqm_nx  = 8'hFF;
    case (state_nx)
      ST_INIT_PRE: begin
        cmd_nx  = CMD_PRE;
        adrs_nx = 12'h400;
      end
      ST_INIT_REF, ST_REF: cmd_nx = CMD_REF;
      ST_INIT_MRS: begin
        cmd_nx  = CMD_MRS;
        ba_nx   = 2'b00;
        adrs_nx = MODE;
      end
      ST_ACT: begin
        cmd_nx  = CMD_ACT;
        ba_nx   = req_bank;
        adrs_nx = req_row;
      end
      ST_RW: begin
        cmd_nx  = wr_q ? CMD_WR : CMD_RD;
        ba_nx   = bank_q;
        adrs_nx = {2'b00, col_q};
        dqm_nx  = wr_q ? mask_q : 8'h00;
      end
      ST_RWAIT: dqm_nx = wr_q ? 8'hFF : 8'h00;
      ST_PRE: begin
        cmd_nx  = CMD_PRE;
        ba_nx   = bank_q;
        adrs_nx = 12'h000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INIT_WAIT;
      tmr         <= TW'(INIT_WAIT);
      init_ref2   <= 1'b0;
      cmd_q       <= CMD_DESEL;
      sd_ba       <= 2'b00;
      sd_adrs     <= 12'h000;
      sd_dqm_l    <= 8'hFF;
      rsp_done    <= 1'b0;
      init_done   <= 1'b0;
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      state     <= state_nx;
      tmr       <= tmr_nx;
      init_ref2 <= init_ref2_nx;
      cmd_q     <= cmd_nx;
      sd_ba     <= ba_nx;
      sd_adrs   <= adrs_nx;
      sd_dqm_l  <= dqm_nx;
      rsp_done  <= (state == ST_RP) && (state_nx == ST_IDLE);
      if (state_nx == ST_IDLE) init_done <= 1'b1;
      if (init_done) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // a REF going out on the wrap edge consumes the old request, so no overrun
      if (ref_wrap && ref_pend && !ref_issue) ref_overrun <= 1'b1;
      ref_pend <= ref_wrap || (ref_pend && !ref_issue);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q   <= req_write;
      bank_q <= req_bank;
      col_q  <= req_col;
      mask_q <= req_mask;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_seq.sv
// Bench for sdram_cmd_seq: a default instance and a short-refresh-interval instance, each compared every
// cycle against a model that schedules the expected per-cycle pin values of each operation in a ring buffer.
module tb_sdram_cmd_seq;

  localparam int N         = 2;
  localparam int INIT_WAIT = 16;
  localparam int TRCD      = 2;
  localparam int CL        = 2;
  localparam int TWR       = 2;
  localparam int TRP       = 2;
  localparam int TRFC      = 6;
  localparam logic [11:0] MODE = 12'h022;
  localparam int NCYC      = 3400;
  localparam int RQ        = 64;

  localparam logic [3:0] C_DESEL = 4'b1111;
  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_RD    = 4'b0101;
  localparam logic [3:0] C_WR    = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;

  typedef struct {
    logic [3:0]  cmd;
    bit          ba_chk;
    logic [1:0]  ba;
    logic [11:0] amask;
    logic [11:0] adrs;
    logic [7:0]  dqm;
    bit          rsp;
    bit          idle;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [1:0]  req_bank  [N];
  logic [11:0] req_row   [N];
  logic [9:0]  req_col   [N];
  logic [7:0]  req_mask  [N];
  logic        rsp_done  [N];
  logic        init_done [N];
  logic        ref_overrun [N];
  logic        sd_cs_    [N];
  logic        sd_ras_   [N];
  logic        sd_cas_   [N];
  logic        sd_we_    [N];
  logic [1:0]  sd_ba     [N];
  logic [11:0] sd_adrs   [N];
  logic [7:0]  sd_dqm_l  [N];

  sdram_cmd_seq u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_bank(req_bank[0]), .req_row(req_row[0]), .req_col(req_col[0]), .req_mask(req_mask[0]),
    .rsp_done(rsp_done[0]), .init_done(init_done[0]), .ref_overrun(ref_overrun[0]),
    .sd_cs_(sd_cs_[0]), .sd_ras_(sd_ras_[0]), .sd_cas_(sd_cas_[0]), .sd_we_(sd_we_[0]),
    .sd_ba(sd_ba[0]), .sd_adrs(sd_adrs[0]), .sd_dqm_l(sd_dqm_l[0])
  );

  sdram_cmd_seq #(.TREFI(8)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_bank(req_bank[1]), .req_row(req_row[1]), .req_col(req_col[1]), .req_mask(req_mask[1]),
    .rsp_done(rsp_done[1]), .init_done(init_done[1]), .ref_overrun(ref_overrun[1]),
    .sd_cs_(sd_cs_[1]), .sd_ras_(sd_ras_[1]), .sd_cas_(sd_cas_[1]), .sd_we_(sd_we_[1]),
    .sd_ba(sd_ba[1]), .sd_adrs(sd_adrs[1]), .sd_dqm_l(sd_dqm_l[1])
  );

  cyc_t rq [N][RQ];
  int   rh [N];
  int   rn [N];
  cyc_t cur [N];
  bit   pend [N];
  bit   ovr [N];
  bit   inited [N];
  int   t_init [N];
  int   trefi [N];
  bit   has_req [N];
  int   nreq [N];
  int   acc_cyc [N];
  int   cyc;
  int   checks;
  int   errors;

  task automatic check_eq(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [3:0] cmd, input bit ba_chk, input logic [1:0] ba,
                      input logic [11:0] amask, input logic [11:0] adrs, input logic [7:0] dqm,
                      input bit rsp, input bit idle);
    cyc_t r;
    r.cmd = cmd; r.ba_chk = ba_chk; r.ba = ba; r.amask = amask; r.adrs = adrs;
    r.dqm = dqm; r.rsp = rsp; r.idle = idle;
    rq[i][(rh[i] + rn[i]) % RQ] = r;
    rn[i]++;
  endtask

  task automatic push_nops(input int i, input int n, input logic [7:0] dqm);
    for (int k = 0; k < n; k++) push(i, C_NOP, 1'b0, 2'b00, 12'h000, 12'h000, dqm, 1'b0, 1'b0);
  endtask

  // expected stream from a reset edge: DESEL, then the whole power-up sequence
  task automatic model_reset(input int i);
    rh[i] = 0; rn[i] = 0;
    pend[i] = 1'b0; ovr[i] = 1'b0; inited[i] = 1'b0;
    push(i, C_DESEL, 1'b1, 2'b00, 12'hFFF, 12'h000, 8'hFF, 1'b0, 1'b0);
    push_nops(i, INIT_WAIT, 8'hFF);
    push(i, C_PRE, 1'b0, 2'b00, 12'h400, 12'h400, 8'hFF, 1'b0, 1'b0);
    push_nops(i, TRP - 1, 8'hFF);
    for (int k = 0; k < 2; k++) begin
      push(i, C_REF, 1'b0, 2'b00, 12'h000, 12'h000, 8'hFF, 1'b0, 1'b0);
      push_nops(i, TRFC - 1, 8'hFF);
    end
    push(i, C_MRS, 1'b1, 2'b00, 12'hFFF, MODE, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic step_check(input int i);
    if (rn[i] == 0) begin
      cur[i].cmd = C_NOP; cur[i].ba_chk = 1'b0; cur[i].ba = 2'b00; cur[i].amask = 12'h000;
      cur[i].adrs = 12'h000; cur[i].dqm = 8'hFF; cur[i].rsp = 1'b0; cur[i].idle = 1'b1;
    end else begin
      cur[i] = rq[i][rh[i]];
    end
    if (cur[i].idle && !inited[i]) begin
      inited[i] = 1'b1;
      t_init[i] = cyc;
    end
    check_eq("cmd", i, 32'({sd_cs_[i], sd_ras_[i], sd_cas_[i], sd_we_[i]}), 32'(cur[i].cmd));
    if (cur[i].ba_chk) check_eq("ba", i, 32'(sd_ba[i]), 32'(cur[i].ba));
    if (cur[i].amask != 12'h000)
      check_eq("adrs", i, 32'(sd_adrs[i] & cur[i].amask), 32'(cur[i].adrs & cur[i].amask));
    check_eq("dqm_l", i, 32'(sd_dqm_l[i]), 32'(cur[i].dqm));
    check_eq("rsp_done", i, 32'(rsp_done[i]), 32'(cur[i].rsp));
    check_eq("init_done", i, 32'(init_done[i]), 32'(inited[i]));
    check_eq("req_ready", i, 32'(req_ready[i]), 32'(cur[i].idle && !pend[i]));
    check_eq("ref_overrun", i, 32'(ref_overrun[i]), 32'(ovr[i]));
  endtask

  // what the coming clock edge does, given the inputs now driven
  task automatic step_advance(input int i, input bit rst);
    bit issue, acc, wrap;
    if (rst) begin
      model_reset(i);
    end else begin
      issue = cur[i].idle && pend[i];
      acc   = cur[i].idle && !pend[i] && req_valid[i];
      wrap  = inited[i] && (((cyc - t_init[i] + 1) % trefi[i]) == 0);
      if (wrap && pend[i] && !issue) ovr[i] = 1'b1;
      pend[i] = wrap || (pend[i] && !issue);
      if (rn[i] > 0) begin
        rh[i] = (rh[i] + 1) % RQ;
        rn[i]--;
      end
      if (issue) begin
        push(i, C_REF, 1'b0, 2'b00, 12'h000, 12'h000, 8'hFF, 1'b0, 1'b0);
        push_nops(i, TRFC - 1, 8'hFF);
      end
      if (acc) begin
        push(i, C_ACT, 1'b1, req_bank[i], 12'hFFF, req_row[i], 8'hFF, 1'b0, 1'b0);
        push_nops(i, TRCD - 1, 8'hFF);
        push(i, req_write[i] ? C_WR : C_RD, 1'b1, req_bank[i], 12'hFFF, {2'b00, req_col[i]},
             req_write[i] ? req_mask[i] : 8'h00, 1'b0, 1'b0);
        push_nops(i, req_write[i] ? TWR : CL, req_write[i] ? 8'hFF : 8'h00);
        push(i, C_PRE, 1'b1, req_bank[i], 12'h400, 12'h000, 8'hFF, 1'b0, 1'b0);
        push_nops(i, TRP, 8'hFF);
        push(i, C_NOP, 1'b0, 2'b00, 12'h000, 12'h000, 8'hFF, 1'b1, 1'b1);
        has_req[i] = 1'b0;
        nreq[i]++;
        acc_cyc[i] = cyc;
      end
    end
  endtask

  task automatic drive(input int i, input int pct);
    if (!has_req[i] && (int'($urandom_range(99)) < pct)) begin
      has_req[i] = 1'b1;
      if (i == 0 && nreq[0] == 0) begin
        req_write[i] = 1'b0; req_bank[i] = 2'd2; req_row[i] = 12'h5A5; req_col[i] = 10'h03C;
        req_mask[i] = 8'($urandom);
      end else if (i == 0 && nreq[0] == 1) begin
        req_write[i] = 1'b1; req_bank[i] = 2'd1; req_row[i] = 12'h0F3; req_col[i] = 10'h2A5;
        req_mask[i] = 8'hF0;
      end else begin
        req_write[i] = 1'($urandom);
        req_bank[i]  = 2'($urandom);
        req_row[i]   = 12'($urandom);
        req_col[i]   = 10'($urandom);
        req_mask[i]  = 8'($urandom);
      end
    end
    req_valid[i] = has_req[i];
  endtask

  initial begin
    bit rst_nx;
    bit rcd_done;
    int rst_left;
    checks = 0; errors = 0; cyc = 0;
    rcd_done = 1'b0; rst_left = 0;
    trefi[0] = 64; trefi[1] = 8;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      has_req[i] = 1'b0; nreq[i] = 0; acc_cyc[i] = -100; t_init[i] = 0;
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_bank[i] = 2'b00;
      req_row[i] = 12'h000; req_col[i] = 10'h000; req_mask[i] = 8'hFF;
      model_reset(i);
    end
    @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      @(negedge clk);
      for (int i = 0; i < N; i++) step_check(i);
      rst_nx = 1'b0;
      if (c < 3) begin
        rst_nx = 1'b1;
      end else if (!rcd_done && c > 1000 && c == acc_cyc[0] + 2) begin
        rst_nx   = 1'b1;  // lands on the RCD cycle of instance 0
        rcd_done = 1'b1;
      end else if (rst_left > 0) begin
        rst_nx = 1'b1;
        rst_left--;
      end else if (c < 2800 && $urandom_range(499) == 0) begin
        rst_nx   = 1'b1;
        rst_left = int'($urandom_range(2));
      end
      reset = rst_nx;
      for (int i = 0; i < N; i++) drive(i, (c < 1500) ? 30 : 100);
      for (int i = 0; i < N; i++) step_advance(i, rst_nx);
    end
    @(negedge clk);
    cyc = NCYC;
    check_eq("overrun_short_trefi", 1, 32'(ref_overrun[1]), 32'd1);
    check_eq("overrun_default_trefi", 0, 32'(ref_overrun[0]), 32'd0);
    check_eq("rcd_reset_hit", 0, 32'(rcd_done), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
